cv32e40p_ft_replica_ctrl: RTL and testbench
===========================================

# cv32e40p_ft_replica_ctrl

Controller for one triplicated fault-tolerant unit (fetch FSM, decoder, etc.). It watches the unit's per-replica `is_broken` flags and voter error pulses. It owns the unit's `set_broken` inputs, latching a failed replica out of service (quarantine) and sequencing a software-requested re-admission with a settle window. It also counts detected and corrected errors, and signals fatal loss of redundancy to the core's FT status logic.

## Interface
Parameters:
- `CNT_W`, 16: width of each error counter (saturating).
- `RELEASE_WAIT`, 8: settle cycles after re-admission before `is_broken_i` is re-sampled; must be ≥ 1.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `is_broken_i`  in  3  per-replica broken flag from the unit's breakage monitors.
- `err_detected_i`  in  1  unit voter error-detected pulse.
- `err_corrected_i`  in  1  unit voter error-corrected pulse.
- `force_valid_i`  in  1  software request to quarantine replicas.
- `force_mask_i`  in  3  replicas to quarantine; sampled on force handshake.
- `force_ready_o`  out  1  force request acceptable.
- `release_valid_i`  in  1  software request to re-admit all quarantined replicas.
- `release_ready_o`  out  1  release request acceptable.
- `clr_cnt_i`  in  1  clear both counters.
- `set_broken_o`  out  3  quarantine mask, wired to the unit's `set_broken_i`.
- `state_o`  out  2  FSM state encoding.
- `fatal_o`  out  1  two or more replicas lost.
- `err_det_cnt_o`  out  `CNT_W`  count of `err_detected_i` cycles.
- `err_cor_cnt_o`  out  `CNT_W`  count of `err_corrected_i` cycles.

## Operation
- Register `q[2:0]` drives `set_broken_o` directly. `state_o`, `fatal_o`, counters and `q` are all registered.
- States: NORMAL=0, DEGRADED=1, RELEASE=2, FATAL=3.
- Force handshake:
  - `force_ready_o` is 1 in NORMAL and DEGRADED, 0 in RELEASE and FATAL.
  - The request is accepted when valid and ready are both 1.
- Release handshake:
  - `release_ready_o` is 1 only in DEGRADED.
  - The request is accepted when valid and ready are both 1.
- NORMAL and DEGRADED:
  - `q_next = q | is_broken_i | (force accepted ? force_mask_i : 0)`. Capture is sticky.
  - Next state from popcount(`q_next`): 0 → NORMAL, 1 → DEGRADED, ≥2 → FATAL.
  - Release accepted (DEGRADED only): `q_next = 0`, load timer with `RELEASE_WAIT`, go to RELEASE. This overrides same-cycle capture.
- RELEASE:
  - `q` holds 0 and `is_broken_i` is ignored while the timer decrements.
  - In the cycle the timer equals 1: `q_next = is_broken_i`, and next state is chosen by popcount as above. An all-zero `is_broken_i` returns the FSM to NORMAL.
- FATAL:
  - Absorbing; only `rst` exits.
  - `q` still ORs in `is_broken_i`; force is not accepted.
  - `fatal_o` = (state == FATAL).
- Counters:
  - Increment by 1 on each cycle the corresponding input is 1, in every state, and saturate at all-ones.
  - `clr_cnt_i` wins over a same-cycle increment; the result is 0.
- A force with mask 0 is accepted with no effect.
- Force and `is_broken_i` in the same cycle are OR-combined.

## Timing
- Reset values (registered, visible the cycle after `rst` is sampled high and held while `rst` is high):
  - `q` = 0, state NORMAL, timer 0, both counters 0.
  - Hence `set_broken_o` = 0, `state_o` = 0, `fatal_o` = 0, `force_ready_o` = 1, `release_ready_o` = 0.
- `rst` mid-RELEASE or in FATAL aborts immediately to the reset values above.
- `is_broken_i` or an accepted force at cycle t appears on `set_broken_o` and `state_o` at t+1.
- Release accepted at cycle t:
  - `set_broken_o` = 0 and `state_o` = RELEASE from t+1.
  - Re-sample of `is_broken_i` at t+`RELEASE_WAIT`; new state and `q` from t+`RELEASE_WAIT`+1.
- A counter input at t is visible on the counter output at t+1.
- Ready outputs are combinational from state only. There is no combinational path from any input to any output.

## Structure
- Shared FT package `cv32e40p_pkg2_ft` holds:
  - typedef enum logic [1:0] `ft_replica_ctrl_state_e` {NORMAL, DEGRADED, RELEASE, FATAL};
  - constants `FTCTRL_CNT_W` = 16 and `FTCTRL_RELEASE_WAIT` = 8, used as parameter defaults.
- Sub-module `cv32e40p_ft_sat_counter` (parameter `W`; ports `clk`, `rst`, `clr_i`, `inc_i`, `cnt_o`) is instantiated twice, once per counter.
- Popcount and next-state logic are inline.

## Test plan
- Reset with all inputs 0 → `set_broken_o` = 000, `state_o` = 0, `force_ready_o` = 1, `release_ready_o` = 0, counters 0.
- `is_broken_i` = 010 for one cycle then 000 → `set_broken_o` = 010 stays set (sticky), `state_o` = 1.
- From DEGRADED with `q` = 010, release handshake with `RELEASE_WAIT` = 8 and `is_broken_i` = 010 for 3 cycles then 000 → `state_o` = 2 for 8 cycles, then NORMAL and `set_broken_o` = 000.
  - Same scenario with `is_broken_i` = 010 held → returns to DEGRADED with `q` = 010.
- Force with `force_mask_i` = 001 while `is_broken_i` = 100 in the same cycle → `q` = 101, `state_o` = 3, `fatal_o` = 1, `force_ready_o` = 0.
  - A subsequent `release_valid_i` is not accepted.
- `CNT_W` = 4 with `err_detected_i` held for 20 cycles → `err_det_cnt_o` = 15 (saturated).
  - Then `clr_cnt_i` asserted together with `err_detected_i` → count 0.
- `rst` asserted 3 cycles into RELEASE → next cycle `state_o` = 0, `set_broken_o` = 000, timer cleared.

Source files
------------

// File: rtl/cv32e40p_pkg2_ft.sv
// Shared fault-tolerance types and defaults for the replica controllers.
package cv32e40p_pkg2_ft;

  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    DEGRADED = 2'd1,
    RELEASE  = 2'd2,
    FATAL    = 2'd3
  } ft_replica_ctrl_state_e;

  localparam int FTCTRL_CNT_W        = 16;
  localparam int FTCTRL_RELEASE_WAIT = 8;

endpackage

// File: rtl/cv32e40p_ft_sat_counter.sv
// Saturating event counter; clear has priority over increment.
module cv32e40p_ft_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                       cnt_d = '0;
    else if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cv32e40p_ft_replica_ctrl.sv
// Quarantine / re-admission controller for one triplicated unit, plus
// saturating detected/corrected error counters.
module cv32e40p_ft_replica_ctrl
  import cv32e40p_pkg2_ft::*;
#(
  parameter int CNT_W        = FTCTRL_CNT_W,
  parameter int RELEASE_WAIT = FTCTRL_RELEASE_WAIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       is_broken_i,
  input  logic             err_detected_i,
  input  logic             err_corrected_i,
  input  logic             force_valid_i,
  input  logic [2:0]       force_mask_i,
  output logic             force_ready_o,
  input  logic             release_valid_i,
  output logic             release_ready_o,
  input  logic             clr_cnt_i,
  output logic [2:0]       set_broken_o,
  output logic [1:0]       state_o,
  output logic             fatal_o,
  output logic [CNT_W-1:0] err_det_cnt_o,
  output logic [CNT_W-1:0] err_cor_cnt_o
);

  localparam int TW = $clog2(RELEASE_WAIT + 1);

  ft_replica_ctrl_state_e state_q, state_d;
  logic [2:0]    q_q, q_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          fatal_q;
  logic          force_acc, rel_acc, reclass;
  logic [1:0]    pop;

  assign force_ready_o   = (state_q == NORMAL) || (state_q == DEGRADED);
  assign release_ready_o = (state_q == DEGRADED);
  assign force_acc       = force_valid_i & force_ready_o;
  assign rel_acc         = release_valid_i & release_ready_o;

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    timer_d = timer_q;
    reclass = 1'b0;
    pop     = 2'd0;
    case (state_q)
      NORMAL, DEGRADED: begin
        // Release wipes the mask even if a capture lands in the same cycle.
        if (rel_acc) begin
          q_d     = 3'b000;
          timer_d = TW'(RELEASE_WAIT);
          state_d = RELEASE;
        end else begin
          q_d     = q_q | is_broken_i | (force_acc ? force_mask_i : 3'b000);
          reclass = 1'b1;
        end
      end
      RELEASE: begin
        q_d     = 3'b000;
        timer_d = timer_q - TW'(1);
        if (timer_q == TW'(1)) begin
          q_d     = is_broken_i;
          timer_d = '0;
          reclass = 1'b1;
        end
      end
      FATAL: q_d = q_q | is_broken_i;
      default: begin
        state_d = NORMAL;
        q_d     = 3'b000;
        timer_d = '0;
      end
    endcase
    if (reclass) begin
      pop = 2'(q_d[0]) + 2'(q_d[1]) + 2'(q_d[2]);
      if (pop == 2'd0)      state_d = NORMAL;
      else if (pop == 2'd1) state_d = DEGRADED;
      else                  state_d = FATAL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= NORMAL;
      q_q     <= 3'b000;
      timer_q <= '0;
      fatal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      timer_q <= timer_d;
      fatal_q <= (state_d == FATAL);
    end
  end

  assign set_broken_o = q_q;
  assign state_o      = state_q;
  assign fatal_o      = fatal_q;

  cv32e40p_ft_sat_counter #(.W(CNT_W)) u_det_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clr_cnt_i),
    .inc_i (err_detected_i),
    .cnt_o (err_det_cnt_o)
  );

  cv32e40p_ft_sat_counter #(.W(CNT_W)) u_cor_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clr_cnt_i),
    .inc_i (err_corrected_i),
    .cnt_o (err_cor_cnt_o)
  );

endmodule

// File: tb/tb_cv32e40p_ft_replica_ctrl.sv
// Directed bench for the replica controller: quarantine, release, fatal, counters.
module tb_cv32e40p_ft_replica_ctrl;

  localparam int CNT_W = 4;
  localparam int RW    = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       is_broken_i;
  logic             err_detected_i, err_corrected_i;
  logic             force_valid_i;
  logic [2:0]       force_mask_i;
  logic             force_ready_o;
  logic             release_valid_i, release_ready_o;
  logic             clr_cnt_i;
  logic [2:0]       set_broken_o;
  logic [1:0]       state_o;
  logic             fatal_o;
  logic [CNT_W-1:0] err_det_cnt_o, err_cor_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cv32e40p_ft_replica_ctrl #(.CNT_W(CNT_W), .RELEASE_WAIT(RW)) dut (
    .clk             (clk),
    .rst             (rst),
    .is_broken_i     (is_broken_i),
    .err_detected_i  (err_detected_i),
    .err_corrected_i (err_corrected_i),
    .force_valid_i   (force_valid_i),
    .force_mask_i    (force_mask_i),
    .force_ready_o   (force_ready_o),
    .release_valid_i (release_valid_i),
    .release_ready_o (release_ready_o),
    .clr_cnt_i       (clr_cnt_i),
    .set_broken_o    (set_broken_o),
    .state_o         (state_o),
    .fatal_o         (fatal_o),
    .err_det_cnt_o   (err_det_cnt_o),
    .err_cor_cnt_o   (err_cor_cnt_o)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; is_broken_i = 3'b000; err_detected_i = 1'b0; err_corrected_i = 1'b0;
    force_valid_i = 1'b0; force_mask_i = 3'b000; release_valid_i = 1'b0; clr_cnt_i = 1'b0;
    tick(2);
    check("rst_sb",    32'(set_broken_o), 32'h0);
    check("rst_state", 32'(state_o), 32'h0);
    rst = 1'b0;
    tick();
    check("rst_sb2",     32'(set_broken_o), 32'h0);
    check("rst_fready",  32'(force_ready_o), 32'h1);
    check("rst_rready",  32'(release_ready_o), 32'h0);
    check("rst_fatal",   32'(fatal_o), 32'h0);
    check("rst_det",     32'(err_det_cnt_o), 32'h0);
    check("rst_cor",     32'(err_cor_cnt_o), 32'h0);

    // one-cycle broken pulse is sticky
    is_broken_i = 3'b010; tick(); is_broken_i = 3'b000;
    check("deg_sb",    32'(set_broken_o), 32'h2);
    check("deg_state", 32'(state_o), 32'h1);
    tick();
    check("deg_sticky", 32'(set_broken_o), 32'h2);
    check("deg_rready", 32'(release_ready_o), 32'h1);
    check("deg_fready", 32'(force_ready_o), 32'h1);

    // release; broken clears before re-sample -> NORMAL
    release_valid_i = 1'b1; is_broken_i = 3'b010; tick(); release_valid_i = 1'b0;
    check("rel_state",  32'(state_o), 32'h2);
    check("rel_sb",     32'(set_broken_o), 32'h0);
    check("rel_rready", 32'(release_ready_o), 32'h0);
    check("rel_fready", 32'(force_ready_o), 32'h0);
    tick(2); is_broken_i = 3'b000;
    check("rel_ignore", 32'(set_broken_o), 32'h0);
    tick(5);
    check("rel_last",   32'(state_o), 32'h2);
    tick();
    check("rel_norm_state", 32'(state_o), 32'h0);
    check("rel_norm_sb",    32'(set_broken_o), 32'h0);

    // release with broken held -> back to DEGRADED
    is_broken_i = 3'b010; tick();
    check("deg2_state", 32'(state_o), 32'h1);
    release_valid_i = 1'b1; tick(); release_valid_i = 1'b0;
    tick(7);
    check("rel2_last_state", 32'(state_o), 32'h2);
    check("rel2_last_sb",    32'(set_broken_o), 32'h0);
    tick();
    check("rel2_deg_state", 32'(state_o), 32'h1);
    check("rel2_deg_sb",    32'(set_broken_o), 32'h2);
    is_broken_i = 3'b000;

    // reset 3 cycles into RELEASE
    release_valid_i = 1'b1; tick(); release_valid_i = 1'b0;
    tick(2);
    check("rel3_state", 32'(state_o), 32'h2);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rstrel_state", 32'(state_o), 32'h0);
    check("rstrel_sb",    32'(set_broken_o), 32'h0);
    tick(RW + 2);
    check("rstrel_idle",  32'(state_o), 32'h0);

    // zero-mask force has no effect
    force_valid_i = 1'b1; force_mask_i = 3'b000; tick(); force_valid_i = 1'b0;
    check("f0_state", 32'(state_o), 32'h0);
    check("f0_sb",    32'(set_broken_o), 32'h0);

    // force 001 with broken 100 -> FATAL
    force_valid_i = 1'b1; force_mask_i = 3'b001; is_broken_i = 3'b100; tick();
    force_valid_i = 1'b0; force_mask_i = 3'b000; is_broken_i = 3'b000;
    check("fat_sb",     32'(set_broken_o), 32'h5);
    check("fat_state",  32'(state_o), 32'h3);
    check("fat_fatal",  32'(fatal_o), 32'h1);
    check("fat_fready", 32'(force_ready_o), 32'h0);
    release_valid_i = 1'b1; tick(); release_valid_i = 1'b0;
    check("fat_norel_state", 32'(state_o), 32'h3);
    check("fat_norel_sb",    32'(set_broken_o), 32'h5);
    force_valid_i = 1'b1; force_mask_i = 3'b010; tick(); force_valid_i = 1'b0;
    check("fat_noforce", 32'(set_broken_o), 32'h5);
    is_broken_i = 3'b010; tick(); is_broken_i = 3'b000;
    check("fat_or", 32'(set_broken_o), 32'h7);

    // counters run in any state; saturate at 15
    err_detected_i = 1'b1; tick();
    check("det_1", 32'(err_det_cnt_o), 32'h1);
    tick(19);
    check("det_sat", 32'(err_det_cnt_o), 32'hF);
    clr_cnt_i = 1'b1; tick(); clr_cnt_i = 1'b0; err_detected_i = 1'b0;
    check("det_clr", 32'(err_det_cnt_o), 32'h0);
    err_corrected_i = 1'b1; tick(3); err_corrected_i = 1'b0;
    tick();
    check("cor_3", 32'(err_cor_cnt_o), 32'h3);
    check("det_hold0", 32'(err_det_cnt_o), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
